issue_ctrl: RTL and testbench

Issue-stage controller between the instruction decoder and the execute stage. It tracks pending register writes in a scoreboard, stalls on read-after-write and write-after-write hazards, serializes system/CSR instructions, limits multi-cycle mul/div to one outstanding operation, and holds the issued instruction in a single output register with a valid/ready handshake. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/issue_ctrl_pkg.sv | 24 ++
 rtl/issue_ctrl_scoreboard.sv | 62 ++++++
 rtl/issue_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_issue_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: shared types and sizes for the issue-stage controller.
package issue_ctrl_pkg;

  // Architectural register file size and the width of a register index.
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;

  // Controller modes: normal issue, waiting for a serializing instruction to
  // retire, and parked on an illegal instruction until the pipeline flushes.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2
  } issue_state_t;

  // Contents of the single issue register handed to execute.
  typedef struct packed {
    logic [31:0]          instr;
    logic [31:0]          pc;
    logic [REG_IDX_W-1:0] rd;
    logic                 illegal;
  } issue_reg_t;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// issue_ctrl_scoreboard: one busy bit per architectural register, marking
// destinations whose write has been issued but not yet written back.
module issue_ctrl_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int NREGS_P = NREGS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_i,
  input  logic                 set_v_i,
  input  logic [REG_IDX_W-1:0] set_idx_i,
  input  logic                 clr_v_i,
  input  logic [REG_IDX_W-1:0] clr_idx_i,
  input  logic [REG_IDX_W-1:0] rs1_i,
  input  logic                 rs1_v_i,
  input  logic [REG_IDX_W-1:0] rs2_i,
  input  logic                 rs2_v_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic                 rd_v_i,
  output logic                 hazard_o,
  output logic                 empty_o
);

  logic [NREGS_P-1:0] busy_q;
  logic [NREGS_P-1:0] busy_d;

  // Next busy vector: writeback clears first so a same-cycle set on the same
  // index wins; x0 is never busy; a flush wipes everything.
  always_comb begin
    busy_d = busy_q;
    if (clr_v_i) begin
      busy_d[clr_idx_i] = 1'b0;
    end
    if (set_v_i) begin
      busy_d[set_idx_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (clear_i) begin
      busy_d = '0;
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Hazard lookup uses only the registered vector, so a writeback landing
  // this cycle still blocks its dependents until the next one.
  always_comb begin
    hazard_o = (rs1_v_i & busy_q[rs1_i]) |
               (rs2_v_i & busy_q[rs2_i]) |
               (rd_v_i  & busy_q[rd_i]);
    empty_o  = ~|busy_q;
  end

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: issue-stage controller. Accepts decoded instructions into a
// single issue register, blocking on RAW/WAW hazards, a busy mul/div unit and
// serializing instructions, and counts decoder stall cycles.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int NREGS       = issue_ctrl_pkg::NREGS,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   dec_valid_i,
  output logic                   dec_ready_o,
  input  logic [31:0]            dec_instr_i,
  input  logic [31:0]            dec_pc_i,
  input  logic [REG_IDX_W-1:0]   dec_rs1_i,
  input  logic [REG_IDX_W-1:0]   dec_rs2_i,
  input  logic [REG_IDX_W-1:0]   dec_rd_i,
  input  logic                   dec_rs1_v_i,
  input  logic                   dec_rs2_v_i,
  input  logic                   dec_rd_v_i,
  input  logic                   dec_muldiv_i,
  input  logic                   dec_serial_i,
  input  logic                   dec_illegal_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [31:0]            issue_instr_o,
  output logic [31:0]            issue_pc_o,
  output logic [REG_IDX_W-1:0]   issue_rd_o,
  output logic                   issue_illegal_o,
  input  logic                   wb_valid_i,
  input  logic [REG_IDX_W-1:0]   wb_rd_i,
  input  logic                   muldiv_done_i,
  input  logic                   flush_i,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  issue_state_t           state_q;
  issue_state_t           state_d;
  issue_reg_t             issue_q;
  issue_reg_t             issue_d;
  logic                   issue_valid_q;
  logic                   issue_valid_d;
  logic                   muldiv_busy_q;
  logic                   muldiv_busy_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;

  logic sb_hazard;
  logic sb_empty;
  logic sb_set;
  logic issue_free;
  logic serial_ok;
  logic dec_ready;
  logic accept;

  // Busy bits for every destination with an outstanding write.
  issue_ctrl_scoreboard #(
    .NREGS_P (NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (flush_i),
    .set_v_i   (sb_set),
    .set_idx_i (dec_rd_i),
    .clr_v_i   (wb_valid_i),
    .clr_idx_i (wb_rd_i),
    .rs1_i     (dec_rs1_i),
    .rs1_v_i   (dec_rs1_v_i),
    .rs2_i     (dec_rs2_i),
    .rs2_v_i   (dec_rs2_v_i),
    .rd_i      (dec_rd_i),
    .rd_v_i    (dec_rd_v_i),
    .hazard_o  (sb_hazard),
    .empty_o   (sb_empty)
  );

  // Accept decision: only in RUN, with room in the issue register, no hazard,
  // a free mul/div unit for mul/div, and a fully quiet pipeline for a
  // serializing instruction. Held low during reset so every output reads 0.
  always_comb begin
    issue_free = !issue_valid_q || issue_ready_i;
    serial_ok  = !dec_serial_i || (sb_empty && !issue_valid_q);
    dec_ready  = reset_n && (state_q == RUN) && issue_free && !sb_hazard &&
                 !(dec_muldiv_i && muldiv_busy_q) && !flush_i && serial_ok;
    accept     = dec_valid_i && dec_ready;
    sb_set     = accept && dec_rd_v_i && !dec_illegal_i && (dec_rd_i != '0);
  end

  // Issue register: a flush drops the held instruction, an accept loads a new
  // one, otherwise the entry empties once execute takes it.
  always_comb begin
    issue_d       = issue_q;
    issue_valid_d = issue_valid_q;
    if (flush_i) begin
      issue_valid_d = 1'b0;
    end else if (accept) begin
      issue_valid_d   = 1'b1;
      issue_d.instr   = dec_instr_i;
      issue_d.pc      = dec_pc_i;
      issue_d.rd      = dec_rd_i;
      issue_d.illegal = dec_illegal_i;
    end else if (issue_ready_i) begin
      issue_valid_d = 1'b0;
    end
  end

  // Single outstanding mul/div: a new mul/div accept beats a same-cycle done.
  always_comb begin
    muldiv_busy_d = muldiv_busy_q;
    if (flush_i) begin
      muldiv_busy_d = 1'b0;
    end else if (accept && dec_muldiv_i && !dec_illegal_i) begin
      muldiv_busy_d = 1'b1;
    end else if (muldiv_done_i) begin
      muldiv_busy_d = 1'b0;
    end
  end

  // Mode sequencing: serializing instructions drain the pipe, illegal ones
  // park the controller until the trap flushes it.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (accept) begin
            if (dec_illegal_i) begin
              state_d = TRAP;
            end else if (dec_serial_i) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!issue_valid_q && sb_empty) begin
            state_d = RUN;
          end
        end
        TRAP: begin
          state_d = TRAP;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Saturating count of cycles the decoder waited; survives flushes.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (dec_valid_i && !dec_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // All controller state flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
      muldiv_busy_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      issue_q       <= issue_d;
      issue_valid_q <= issue_valid_d;
      muldiv_busy_q <= muldiv_busy_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign dec_ready_o     = dec_ready;
  assign issue_valid_o   = issue_valid_q;
  assign issue_instr_o   = issue_q.instr;
  assign issue_pc_o      = issue_q.pc;
  assign issue_rd_o      = issue_q.rd;
  assign issue_illegal_o = issue_q.illegal;
  assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed scenarios plus a randomized run, all checked
// against a transaction-level model of the issue rules.
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dec_valid_i;
  logic        dec_ready_o;
  logic [31:0] dec_instr_i;
  logic [31:0] dec_pc_i;
  logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic        dec_rs1_v_i, dec_rs2_v_i, dec_rd_v_i;
  logic        dec_muldiv_i, dec_serial_i, dec_illegal_i;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [31:0] issue_instr_o, issue_pc_o;
  logic [4:0]  issue_rd_o;
  logic        issue_illegal_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        muldiv_done_i;
  logic        flush_i;
  logic [31:0] stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: set of registers with pending writes, mul/div flag,
  // controller mode, the held instruction and the stall tally.
  localparam int M_NORMAL  = 0;
  localparam int M_SERIAL  = 1;
  localparam int M_TRAPPED = 2;
  bit          m_pend [0:31];
  bit          m_md;
  int          m_mode;
  bit          m_valid;
  logic [31:0] m_instr, m_pc;
  logic [4:0]  m_rd;
  bit          m_ill;
  longint      m_stall;
  bit          m_last_acc;
  logic [31:0] pc_ctr = 32'h1000;

  issue_ctrl #(.NREGS(32), .STALL_CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_instr_i(dec_instr_i), .dec_pc_i(dec_pc_i),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
    .dec_rs1_v_i(dec_rs1_v_i), .dec_rs2_v_i(dec_rs2_v_i), .dec_rd_v_i(dec_rd_v_i),
    .dec_muldiv_i(dec_muldiv_i), .dec_serial_i(dec_serial_i), .dec_illegal_i(dec_illegal_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_instr_o(issue_instr_o), .issue_pc_o(issue_pc_o),
    .issue_rd_o(issue_rd_o), .issue_illegal_o(issue_illegal_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .muldiv_done_i(muldiv_done_i), .flush_i(flush_i),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic bit pend_any();
    for (int i = 0; i < 32; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit model_ready();
    if (flush_i || m_mode != M_NORMAL) return 1'b0;
    if (m_valid && !issue_ready_i) return 1'b0;
    if (dec_rs1_v_i && m_pend[dec_rs1_i]) return 1'b0;
    if (dec_rs2_v_i && m_pend[dec_rs2_i]) return 1'b0;
    if (dec_rd_v_i && m_pend[dec_rd_i]) return 1'b0;
    if (dec_muldiv_i && m_md) return 1'b0;
    if (dec_serial_i && (m_valid || pend_any())) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_md = 0; m_mode = M_NORMAL; m_valid = 0; m_instr = '0; m_pc = '0;
    m_rd = '0; m_ill = 0; m_stall = 0; m_last_acc = 0;
  endtask

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    bit r, acc, old_valid, old_empty;
    r = model_ready();
    acc = dec_valid_i && r;
    old_valid = m_valid;
    old_empty = !pend_any();
    @(posedge clk);
    if (dec_valid_i && !r && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (flush_i) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_md = 0; m_valid = 0; m_mode = M_NORMAL;
    end else begin
      if (wb_valid_i) m_pend[wb_rd_i] = 1'b0;
      if (acc && dec_rd_v_i && dec_rd_i != 0 && !dec_illegal_i) m_pend[dec_rd_i] = 1'b1;
      if (acc && dec_muldiv_i && !dec_illegal_i) m_md = 1;
      else if (muldiv_done_i) m_md = 0;
      if (acc) begin
        m_valid = 1; m_instr = dec_instr_i; m_pc = dec_pc_i; m_rd = dec_rd_i; m_ill = dec_illegal_i;
      end else if (issue_ready_i) begin
        m_valid = 0;
      end
      if (m_mode == M_SERIAL && !old_valid && old_empty) m_mode = M_NORMAL;
      if (acc) m_mode = dec_illegal_i ? M_TRAPPED : (dec_serial_i ? M_SERIAL : M_NORMAL);
    end
    m_last_acc = acc;
    #1;
  endtask

  task automatic set_dec(input bit v, input int rd, input bit rdv, input int rs1, input bit rs1v,
                         input int rs2, input bit rs2v, input bit md, input bit ser, input bit ill);
    dec_valid_i = v; dec_rd_i = 5'(rd); dec_rd_v_i = rdv;
    dec_rs1_i = 5'(rs1); dec_rs1_v_i = rs1v; dec_rs2_i = 5'(rs2); dec_rs2_v_i = rs2v;
    dec_muldiv_i = md; dec_serial_i = ser; dec_illegal_i = ill;
    dec_instr_i = $urandom; dec_pc_i = pc_ctr; pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic clean();
    dec_valid_i = 0; wb_valid_i = 0; muldiv_done_i = 0; issue_ready_i = 1; flush_i = 1;
    #1; tick();
    flush_i = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; issue_ready_i = 1; wb_valid_i = 0; wb_rd_i = 0; muldiv_done_i = 0; flush_i = 0;
    set_dec(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #12;
    n_checks++;
    if ({dec_ready_o, issue_valid_o, issue_instr_o, issue_pc_o, issue_rd_o, issue_illegal_o, stall_cnt_o} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_outputs: got rdy=%b v=%b instr=%h pc=%h rd=%0d ill=%b cnt=%0d required all 0",
        dec_ready_o, issue_valid_o, issue_instr_o, issue_pc_o, issue_rd_o, issue_illegal_o, stall_cnt_o);
    end
    n_checks++;
    if (dut.u_scoreboard.busy_q !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_busy: got %h required 0", dut.u_scoreboard.busy_q);
    end
    dec_valid_i = 0; reset_n = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_independent();
    for (int k = 1; k <= 3; k++) begin
      set_dec(1, k, 1, 0, 1, 0, 1, 0, 0, 0);
      #1;
      n_checks++;
      if (dec_ready_o !== 1'b1) begin
        n_fail++; $display("[TB] FAIL indep_ready%0d: got %b required 1", k, dec_ready_o);
      end
      tick();
      n_checks++;
      if ({issue_valid_o, issue_rd_o, issue_pc_o} !== {1'b1, 5'(k), m_pc}) begin
        n_fail++; $display("[TB] FAIL indep_issue%0d: got v=%b rd=%0d pc=%h required v=1 rd=%0d pc=%h",
          k, issue_valid_o, issue_rd_o, issue_pc_o, k, m_pc);
      end
    end
    dec_valid_i = 0;
    #1;
    n_checks++;
    if (dut.u_scoreboard.busy_q !== 32'b1110) begin
      n_fail++; $display("[TB] FAIL indep_busy: got %b required 1110", dut.u_scoreboard.busy_q);
    end
    n_checks++;
    if (stall_cnt_o !== 32'd0) begin
      n_fail++; $display("[TB] FAIL indep_stall: got %0d required 0", stall_cnt_o);
    end
  endtask

  task automatic test_raw();
    logic [31:0] cnt0;
    bit exp_rdy [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};
    clean();
    cnt0 = stall_cnt_o;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) set_dec(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      else if (c == 1) set_dec(1, 6, 1, 5, 1, 0, 1, 0, 0, 0);
      wb_valid_i = (c == 2); wb_rd_i = 5;
      #1;
      n_checks++;
      if (dec_ready_o !== exp_rdy[c]) begin
        n_fail++; $display("[TB] FAIL raw_ready_c%0d: got %b required %b", c, dec_ready_o, exp_rdy[c]);
      end
      tick();
    end
    dec_valid_i = 0; wb_valid_i = 0;
    n_checks++;
    if (issue_rd_o !== 5'd6 || issue_valid_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL raw_issue: got v=%b rd=%0d required v=1 rd=6", issue_valid_o, issue_rd_o);
    end
    n_checks++;
    if (stall_cnt_o - cnt0 !== 32'd2 || stall_cnt_o !== m_stall[31:0]) begin
      n_fail++; $display("[TB] FAIL raw_stall_cnt: got %0d (delta %0d) required %0d (delta 2)",
        stall_cnt_o, stall_cnt_o - cnt0, m_stall);
    end
  endtask

  task automatic test_muldiv();
    bit exp_rdy [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};
    clean();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) set_dec(1, 7, 1, 1, 1, 2, 1, 1, 0, 0);
      else if (c == 1) set_dec(1, 8, 1, 3, 1, 0, 0, 1, 0, 0);
      muldiv_done_i = (c == 2);
      #1;
      n_checks++;
      if (dec_ready_o !== exp_rdy[c]) begin
        n_fail++; $display("[TB] FAIL muldiv_ready_c%0d: got %b required %b", c, dec_ready_o, exp_rdy[c]);
      end
      tick();
    end
    dec_valid_i = 0; muldiv_done_i = 0;
    n_checks++;
    if (issue_rd_o !== 5'd8 || issue_valid_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL muldiv_issue: got v=%b rd=%0d required v=1 rd=8", issue_valid_o, issue_rd_o);
    end
  endtask

  task automatic test_serial();
    bit exp_rdy [0:7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    clean();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) set_dec(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      else if (c == 1) set_dec(1, 9, 1, 3, 1, 0, 0, 0, 1, 0);
      else if (c == 4) set_dec(1, 10, 1, 1, 1, 0, 0, 0, 0, 0);
      wb_valid_i = (c == 2) || (c == 5);
      wb_rd_i = (c == 2) ? 5'd3 : 5'd9;
      #1;
      n_checks++;
      if (dec_ready_o !== exp_rdy[c]) begin
        n_fail++; $display("[TB] FAIL serial_ready_c%0d: got %b required %b", c, dec_ready_o, exp_rdy[c]);
      end
      tick();
    end
    dec_valid_i = 0; wb_valid_i = 0;
    n_checks++;
    if (issue_rd_o !== 5'd10 || issue_valid_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL serial_issue: got v=%b rd=%0d required v=1 rd=10", issue_valid_o, issue_rd_o);
    end
  endtask

  task automatic test_illegal();
    clean();
    set_dec(1, 13, 1, 0, 0, 0, 0, 0, 0, 0);
    #1; tick();
    set_dec(1, 11, 1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    n_checks++;
    if (dec_ready_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL illegal_accept: got %b required 1", dec_ready_o);
    end
    tick();
    n_checks++;
    if ({issue_valid_o, issue_illegal_o, issue_rd_o} !== {1'b1, 1'b1, 5'd11}) begin
      n_fail++; $display("[TB] FAIL illegal_issue: got v=%b ill=%b rd=%0d required v=1 ill=1 rd=11",
        issue_valid_o, issue_illegal_o, issue_rd_o);
    end
    n_checks++;
    if (dut.u_scoreboard.busy_q !== 32'h2000) begin
      n_fail++; $display("[TB] FAIL illegal_busy: got %h required 2000", dut.u_scoreboard.busy_q);
    end
    set_dec(1, 12, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (dec_ready_o !== 1'b0) begin
        n_fail++; $display("[TB] FAIL trap_hold_c%0d: got %b required 0", c, dec_ready_o);
      end
      tick();
    end
    flush_i = 1;
    #1; tick();
    flush_i = 0;
    #1;
    n_checks++;
    if (dut.u_scoreboard.busy_q !== 32'h0 || dec_ready_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL flush_recover: got busy=%h rdy=%b required busy=0 rdy=1",
        dut.u_scoreboard.busy_q, dec_ready_o);
    end
    tick();
    dec_valid_i = 0;
    n_checks++;
    if ({issue_valid_o, issue_illegal_o, issue_rd_o} !== {1'b1, 1'b0, 5'd12}) begin
      n_fail++; $display("[TB] FAIL post_flush_issue: got v=%b ill=%b rd=%0d required v=1 ill=0 rd=12",
        issue_valid_o, issue_illegal_o, issue_rd_o);
    end
  endtask

  task automatic test_same_cycle();
    clean();
    set_dec(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    wb_valid_i = 1; wb_rd_i = 4;
    #1;
    n_checks++;
    if (dec_ready_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL same_cycle_ready: got %b required 1", dec_ready_o);
    end
    tick();
    wb_valid_i = 0;
    n_checks++;
    if (dut.u_scoreboard.busy_q !== 32'h10) begin
      n_fail++; $display("[TB] FAIL same_cycle_busy: got %h required 10", dut.u_scoreboard.busy_q);
    end
    set_dec(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    #1; tick();
    set_dec(1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (dec_ready_o !== 1'b1 || dut.u_scoreboard.busy_q !== 32'h10) begin
      n_fail++; $display("[TB] FAIL x0_never_busy: got rdy=%b busy=%h required rdy=1 busy=10",
        dec_ready_o, dut.u_scoreboard.busy_q);
    end
    tick();
    dec_valid_i = 0;
  endtask

  task automatic test_random();
    int idx;
    clean();
    for (int c = 0; c < 400; c++) begin
      if (!dec_valid_i || m_last_acc) begin
        set_dec(($urandom_range(0, 9) < 8), $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 3));
      end
      issue_ready_i = ($urandom_range(0, 9) < 7);
      idx = $urandom_range(1, 7);
      wb_valid_i = m_pend[idx] && ($urandom_range(0, 9) < 4);
      wb_rd_i = 5'(idx);
      muldiv_done_i = m_md && ($urandom_range(0, 3) == 0);
      flush_i = (m_mode == M_TRAPPED) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) < 3);
      #1;
      n_checks++;
      if (dec_ready_o !== model_ready()) begin
        n_fail++; $display("[TB] FAIL rand_ready_c%0d: got %b required %b", c, dec_ready_o, model_ready());
      end
      tick();
      n_checks++;
      if ({issue_valid_o, issue_instr_o, issue_pc_o, issue_rd_o, issue_illegal_o} !==
          {m_valid, m_instr, m_pc, m_rd, m_ill}) begin
        n_fail++; $display("[TB] FAIL rand_issue_c%0d: got v=%b i=%h pc=%h rd=%0d ill=%b required v=%b i=%h pc=%h rd=%0d ill=%b",
          c, issue_valid_o, issue_instr_o, issue_pc_o, issue_rd_o, issue_illegal_o, m_valid, m_instr, m_pc, m_rd, m_ill);
      end
      n_checks++;
      if (stall_cnt_o !== m_stall[31:0]) begin
        n_fail++; $display("[TB] FAIL rand_stall_c%0d: got %0d required %0d", c, stall_cnt_o, m_stall);
      end
      n_checks++;
      if (dut.u_scoreboard.busy_q !== pend_vec()) begin
        n_fail++; $display("[TB] FAIL rand_busy_c%0d: got %h required %h", c, dut.u_scoreboard.busy_q, pend_vec());
      end
    end
    clean();
  endtask

  task automatic test_reset_mid();
    clean();
    set_dec(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    #1; tick();
    set_dec(1, 6, 1, 5, 1, 0, 0, 0, 0, 0);
    #1; tick();
    #1; tick();
    #1;
    reset_n = 0;
    #1;
    n_checks++;
    if ({dec_ready_o, issue_valid_o, issue_instr_o, issue_pc_o, issue_rd_o, issue_illegal_o, stall_cnt_o} !== '0) begin
      n_fail++; $display("[TB] FAIL mid_reset_outputs: got rdy=%b v=%b rd=%0d ill=%b cnt=%0d required all 0",
        dec_ready_o, issue_valid_o, issue_rd_o, issue_illegal_o, stall_cnt_o);
    end
    n_checks++;
    if (dut.u_scoreboard.busy_q !== 32'h0) begin
      n_fail++; $display("[TB] FAIL mid_reset_busy: got %h required 0", dut.u_scoreboard.busy_q);
    end
    model_reset();
    dec_valid_i = 0;
    reset_n = 1;
    @(posedge clk); #1;
    set_dec(1, 6, 1, 5, 1, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (dec_ready_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL post_reset_ready: got %b required 1", dec_ready_o);
    end
    tick();
    dec_valid_i = 0;
  endtask

  initial begin
    $display("[TB] starting issue_ctrl bench");
    test_reset();
    test_independent();
    test_raw();
    test_muldiv();
    test_serial();
    test_illegal();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
